nios_ii_audio_sample_in: RTL and testbench

Avalon-MM slave that carries audio samples from the hardware audio path into the NIOS II, the receive-side counterpart of the 24-bit sample output port. Buffers samples arriving on a valid strobe in a small FIFO. Exposes data, status, interrupt-mask and control registers to the processor. Raises a level interrupt so firmware can drain samples in bursts.

---
 rtl/nios_ii_audio_sample_in_pkg.sv | 29 ++
 rtl/audio_sync_fifo.sv | 55 +++++
 rtl/nios_ii_audio_sample_in.sv | 105 ++++++++++
 tb/tb_nios_ii_audio_sample_in.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios_ii_audio_sample_in_pkg.sv
// Shared register map and bit positions for the audio sample input port.
package nios_ii_audio_sample_in_pkg;

  localparam int unsigned BUS_W = 32;

  // Register addresses
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_CONTROL = 2'd3
  } reg_addr_e;

  // STATUS bit positions
  localparam int unsigned STATUS_COUNT_W   = 8;
  localparam int unsigned STATUS_EMPTY_BIT = 8;
  localparam int unsigned STATUS_FULL_BIT  = 9;
  localparam int unsigned STATUS_OVF_BIT   = 10;

  // CONTROL bit positions (self-clearing pulses)
  localparam int unsigned CTRL_CLR_OVF_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 1;

  // IRQMASK bit positions
  localparam int unsigned IRQMASK_W         = 2;
  localparam int unsigned IRQ_NOT_EMPTY_BIT = 0;
  localparam int unsigned IRQ_OVF_BIT       = 1;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock sample FIFO with flush; one push and one pop per cycle.
module audio_sync_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_push;

  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Pointer and occupancy state; flush overrides any push or pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Sample storage, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/nios_ii_audio_sample_in.sv
// Avalon-MM slave buffering incoming audio samples for the NIOS II with a level irq.
module nios_ii_audio_sample_in
  import nios_ii_audio_sample_in_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  reg_addr_e             addr;
  logic                  rd_req;
  logic                  wr_req;
  logic                  pop_req;
  logic                  flush;
  logic                  clr_ovf;
  logic                  mask_we;
  logic                  ovf_event;
  logic [DATA_W-1:0]     fifo_dout;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [IRQMASK_W-1:0]  irq_mask;
  logic                  unused_wdata;

  // Avalon strobe decode
  always_comb begin
    addr    = reg_addr_e'(address);
    rd_req  = chipselect & ~read_n;
    wr_req  = chipselect & ~write_n;
    pop_req = rd_req  & (addr == ADDR_DATA);
    mask_we = wr_req  & (addr == ADDR_IRQMASK);
    flush   = wr_req  & (addr == ADDR_CONTROL) & writedata[CTRL_FLUSH_BIT];
    clr_ovf = wr_req  & (addr == ADDR_CONTROL) & writedata[CTRL_CLR_OVF_BIT];
    // Full implies non-empty, so a pop request always frees the slot here
    ovf_event = in_valid & full & ~pop_req & ~flush;
  end

  audio_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop_req),
    .flush (flush),
    .din   (in_port),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)          overflow <= 1'b0;
    else if (ovf_event) overflow <= 1'b1;
    else if (clr_ovf)   overflow <= 1'b0;
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset)        irq_mask <= '0;
    else if (mask_we) irq_mask <= writedata[IRQMASK_W-1:0];
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    unique case (addr)
      ADDR_DATA: begin
        if (!empty) readdata = BUS_W'(fifo_dout);
      end
      ADDR_STATUS: begin
        readdata[STATUS_COUNT_W-1:0] = STATUS_COUNT_W'(count);
        readdata[STATUS_EMPTY_BIT]   = empty;
        readdata[STATUS_FULL_BIT]    = full;
        readdata[STATUS_OVF_BIT]     = overflow;
      end
      ADDR_IRQMASK: readdata[IRQMASK_W-1:0] = irq_mask;
      ADDR_CONTROL: readdata = '0;
      default:      readdata = '0;
    endcase
  end

  // Level interrupt from registered state only
  assign irq = (irq_mask[IRQ_NOT_EMPTY_BIT] & ~empty) | (irq_mask[IRQ_OVF_BIT] & overflow);

  assign unused_wdata = ^writedata[BUS_W-1:IRQMASK_W];

endmodule

// File: tb/tb_nios_ii_audio_sample_in.sv
// Self-checking bench: directed vector table, corner sequences, random run vs queue model.
module tb_nios_ii_audio_sample_in;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_port;
  logic              in_valid;
  logic [1:0]        address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

  nios_ii_audio_sample_in #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [23:0] din;
    bit          cs;
    bit          rn;
    bit          wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  // Drive one cycle of inputs just after the edge and wait for the mid-cycle sample point
  task automatic cyc(input bit rst, input bit iv, input logic [23:0] d, input bit cs,
                     input bit rn, input bit wn, input logic [1:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset = rst; in_valid = iv; in_port = d; chipselect = cs;
    read_n = rn; write_n = wn; address = a; writedata = wd;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Convenience wrappers
  task automatic push(input logic [23:0] d);   cyc(0, 1, d, 0, 1, 1, 2'd1, 0); endtask
  task automatic idle(input logic [1:0] a);     cyc(0, 0, 0, 0, 1, 1, a, 0);   endtask
  task automatic pop_rd();                      cyc(0, 0, 0, 1, 0, 1, 2'd0, 0); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] wd); cyc(0, 0, 0, 1, 1, 0, a, wd); endtask

  // Reference model state
  int unsigned mq[$];
  bit          m_ovf;
  logic [1:0]  m_mask;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(mq.size());
    if (mq.size() == 0)     s |= 32'h100;
    if (mq.size() == DEPTH) s |= 32'h200;
    if (m_ovf)              s |= 32'h400;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (mq.size() != 0) ? 32'(mq[0]) : 32'h0;
      2'd1:    return m_status();
      2'd2:    return 32'(m_mask);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_irq();
    return (m_mask[0] && mq.size() != 0) || (m_mask[1] && m_ovf);
  endfunction

  // Apply the current inputs to the model as the next clock edge would
  task automatic m_step();
    bit rd, wrq, pop, fl, clr, oe;
    if (reset) begin
      mq.delete(); m_ovf = 0; m_mask = 0;
      return;
    end
    rd  = chipselect && !read_n;
    wrq = chipselect && !write_n;
    pop = rd && address == 2'd0 && mq.size() != 0;
    fl  = wrq && address == 2'd3 && writedata[1];
    clr = wrq && address == 2'd3 && writedata[0];
    oe  = in_valid && mq.size() == DEPTH && !pop && !fl;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (in_valid && mq.size() < DEPTH) mq.push_back(int'(in_port));
    end
    if (oe) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (wrq && address == 2'd2) m_mask = writedata[1:0];
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1; in_valid = 0; in_port = 0; chipselect = 0;
    read_n = 1; write_n = 1; address = 0; writedata = 0;

    //            iv  din        cs rn wn a  wd  exp_rd        irq
    vecs.push_back('{0, 24'h0,      1, 0, 1, 0, 0, 32'h0,        0});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 1, 0, 32'h100,      0});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 2, 0, 32'h0,        0});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 3, 0, 32'h0,        0});
    vecs.push_back('{1, 24'h123456, 0, 1, 1, 1, 0, 32'h100,      0});
    vecs.push_back('{1, 24'hABCDEF, 0, 1, 1, 1, 0, 32'h001,      0});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h002,      0});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 0, 0, 32'h00123456, 0});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h001,      0});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 0, 0, 32'h00ABCDEF, 0});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h100,      0});
    vecs.push_back('{1, 24'h000055, 1, 0, 1, 0, 0, 32'h0,        0});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h001,      0});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 0, 0, 32'h55,       0});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h100,      0});
    vecs.push_back('{0, 24'h0,      1, 1, 0, 2, 1, 32'h0,        0});
    vecs.push_back('{1, 24'h000777, 1, 0, 1, 2, 0, 32'h1,        0});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h001,      1});
    vecs.push_back('{0, 24'h0,      1, 0, 1, 0, 0, 32'h777,      1});
    vecs.push_back('{0, 24'h0,      0, 1, 1, 1, 0, 32'h100,      0});
    vecs.push_back('{0, 24'h0,      1, 1, 0, 2, 0, 32'h1,        0});

    cyc(1, 0, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      cyc(0, vecs[i].iv, vecs[i].din, vecs[i].cs, vecs[i].rn, vecs[i].wn, vecs[i].a, vecs[i].wd);
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Overflow on the ninth sample, ordered drain, then clear
    for (int i = 0; i < 9; i++) push(24'h100 + 24'(i));
    idle(1); chk("ovf_status", readdata, 32'h608);
    for (int i = 0; i < 8; i++) begin
      pop_rd(); chk($sformatf("drain%0d", i), readdata, 32'h100 + 32'(i));
    end
    idle(1); chk("drained_status", readdata, 32'h500);
    wr(3, 1); chk("control_reads0", readdata, 32'h0);
    idle(1); chk("ovf_cleared", readdata, 32'h100);

    // Push and pop together while full, then flush with a concurrent strobe
    for (int i = 0; i < 8; i++) push(24'h200 + 24'(i));
    cyc(0, 1, 24'h2FF, 1, 0, 1, 0, 0); chk("full_pushpop_rd", readdata, 32'h200);
    idle(1); chk("full_pushpop_status", readdata, 32'h208);
    pop_rd(); chk("full_pushpop_order", readdata, 32'h201);
    cyc(0, 1, 24'h333, 1, 1, 0, 3, 2);
    idle(1); chk("flush_status", readdata, 32'h100);

    // Overflow interrupt, set-wins against a simultaneous clear
    wr(2, 2);
    idle(2); chk("mask2", readdata, 32'h2); chk("irq_mask2_idle", 32'(irq), 0);
    for (int i = 0; i < 9; i++) push(24'h300 + 24'(i));
    idle(1); chk("ovf2_status", readdata, 32'h608); chk("irq_ovf", 32'(irq), 1);
    cyc(0, 1, 24'h444, 1, 1, 0, 3, 1);
    idle(1); chk("set_wins_status", readdata, 32'h608); chk("irq_set_wins", 32'(irq), 1);
    wr(3, 1); chk("irq_before_clear", 32'(irq), 1);
    idle(1); chk("cleared_status", readdata, 32'h208); chk("irq_cleared", 32'(irq), 0);

    // Reset with samples buffered and interrupts enabled
    wr(3, 2);
    for (int i = 0; i < 5; i++) push(24'h500 + 24'(i));
    wr(2, 3);
    idle(1); chk("pre_reset_status", readdata, 32'h005); chk("irq_pre_reset", 32'(irq), 1);
    cyc(1, 1, 24'h999, 0, 1, 1, 1, 0);
    idle(1); chk("post_reset_status", readdata, 32'h100); chk("irq_post_reset", 32'(irq), 0);
    idle(2); chk("post_reset_mask", readdata, 32'h0);

    // Randomized run against the queue model
    mq.delete(); m_ovf = 0; m_mask = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rst, iv, cs, rn, wn;
      logic [1:0]  a;
      logic [31:0] wd;
      rst = ($urandom_range(0, 249) == 0);
      iv  = ($urandom_range(0, 99) < 55);
      cs  = ($urandom_range(0, 9) < 7);
      rn  = ($urandom_range(0, 9) < 5);
      wn  = ($urandom_range(0, 9) < 8);
      a   = 2'($urandom_range(0, 3));
      wd  = $urandom;
      if (a == 2'd3 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      cyc(rst, iv, 24'($urandom), cs, rn, wn, a, wd);
      chk($sformatf("rand%0d_rd", n), readdata, m_read(a));
      chk($sformatf("rand%0d_irq", n), 32'(irq), 32'(m_irq()));
      m_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
